// File: rtl/wbs_multi_mem_ctrl.sv
// Wishbone slave fronting NUM_CH wide SRAM channels through a shared 32-bit-word staging buffer.
// Define WBS_MEM_ERR_EN to add wbs_err_o and error-terminate unmapped accesses.
module wbs_multi_mem_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
`ifdef WBS_MEM_ERR_EN
  output logic                     wbs_err_o,
`endif
  output logic [31:0]              wbs_dat_o,
  output logic                     wbs_mode,
  output logic                     wbs_debug,
  output logic [NUM_CH-1:0]        mem_csb,
  output logic [NUM_CH-1:0]        mem_web,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [NUM_CH*DATA_W-1:0] mem_rdata
);
  localparam int WORDS = (DATA_W + 31) / 32;
  localparam int WI_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef WBS_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_CAP, ACK} state_t;

  typedef struct packed {
    logic            ctrl;
    logic [1:0]      reg_i;
    logic            chan;
    logic [2:0]      ch;
    logic [WI_W-1:0] k;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] a);
    dec_t d;
    logic [7:0] off;
    d       = '0;
    off     = a[31:24] - 8'h31;
    d.k     = a[WI_W-1:0];
    d.ch    = off[2:0];
    d.chan  = (off < 8'(NUM_CH)) && ({1'b0, d.k} < (WI_W+1)'(WORDS));
    d.reg_i = a[3:2];
    d.ctrl  = (a[31:24] == 8'h30) && (a[23:4] == 20'h0) && (a[1:0] == 2'b00) && (a[3:2] != 2'b11);
    return d;
  endfunction

  state_t                  state;
  logic [1:0]              wcnt;
  dec_t                    di, dq;
  logic [ADDR_W-1:0]       di_ent;
  logic [WORDS*32-1:0]     stg, stg_nx, rd_ent;
  logic [31:0]             cnt, rd_word, ctrl_word;
  logic [NUM_CH-1:0]       ch_oh;
  logic                    acc, unm, last;

  assign acc    = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign di     = decode(wbs_adr_i);
  assign di_ent = wbs_adr_i[WI_W+ADDR_W-1:WI_W];
  assign unm    = !di.ctrl && !di.chan;
  assign last   = di.chan && (di.k == WI_W'(WORDS - 1));
  assign ch_oh  = NUM_CH'(1) << di.ch;

  // Byte-merged staging image, also the data a committing write sends out.
  always_comb begin
    stg_nx = stg;
    if (di.chan)
      for (int b = 0; b < 4; b++)
        if (wbs_sel_i[b]) stg_nx[int'(di.k)*32 + 8*b +: 8] = wbs_dat_i[8*b +: 8];
  end

  always_comb begin
    rd_ent  = '0;
    rd_word = '0;
    if (dq.chan) begin
      rd_ent[DATA_W-1:0] = mem_rdata[int'(dq.ch)*DATA_W +: DATA_W];
      rd_word            = rd_ent[int'(dq.k)*32 +: 32];
    end
    case (dq.reg_i)
      2'd0:    ctrl_word = {31'b0, wbs_mode};
      2'd1:    ctrl_word = {31'b0, wbs_debug};
      default: ctrl_word = cnt;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wcnt      <= '0;
      dq        <= '0;
      stg       <= '0;
      cnt       <= '0;
      wbs_ack_o <= 1'b0;
`ifdef WBS_MEM_ERR_EN
      wbs_err_o <= 1'b0;
`endif
      wbs_dat_o <= '0;
      wbs_mode  <= 1'b0;
      wbs_debug <= 1'b0;
      mem_csb   <= '1;
      mem_web   <= '1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
`ifdef WBS_MEM_ERR_EN
      wbs_err_o <= 1'b0;
`endif
      mem_csb   <= '1;
      mem_web   <= '1;
      case (state)
        IDLE: if (acc) begin
          dq <= di;
          if (wbs_we_i || (ERR_EN && unm)) begin
            state <= ACK;
`ifdef WBS_MEM_ERR_EN
            wbs_err_o <= unm;
            wbs_ack_o <= !unm;
`else
            wbs_ack_o <= 1'b1;
`endif
            if (wbs_we_i && di.chan) begin
              stg <= stg_nx;
              // Last word of the entry: the ACK cycle doubles as the commit cycle.
              if (last) begin
                mem_csb   <= ~ch_oh;
                mem_web   <= ~ch_oh;
                mem_addr  <= di_ent;
                mem_wdata <= stg_nx[DATA_W-1:0];
                cnt       <= cnt + 32'd1;
              end
            end
            if (wbs_we_i && di.ctrl && wbs_sel_i[0]) begin
              if (di.reg_i == 2'd0) wbs_mode  <= wbs_dat_i[0];
              if (di.reg_i == 2'd1) wbs_debug <= wbs_dat_i[0];
            end
          end else begin
            state <= RD_ISSUE;
            if (di.chan) begin
              mem_csb  <= ~ch_oh;
              mem_addr <= di_ent;
            end
          end
        end
        RD_ISSUE: begin
          if (MEM_LAT == 1) state <= RD_CAP;
          else begin
            state <= RD_WAIT;
            wcnt  <= 2'(MEM_LAT - 2);
          end
        end
        RD_WAIT: begin
          wcnt <= wcnt - 2'd1;
          if (wcnt == 2'd0) state <= RD_CAP;
        end
        RD_CAP: begin
          wbs_dat_o <= dq.chan ? rd_word : (dq.ctrl ? ctrl_word : 32'h0);
          wbs_ack_o <= 1'b1;
          state     <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/wbs_multi_mem_ctrl.md
WBS_MULTI_MEM_CTRL -- requirements
Module: wbs_multi_mem_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of memory channels, 1..8.
REQ-002 Parameter DATA_W, default 64: channel entry width, 1..256; WORDS = ceil(DATA_W/32); WI_W = max(1, clog2(WORDS)).
REQ-003 Parameter ADDR_W, default 6: channel entry address width.
REQ-004 Parameter MEM_LAT, default 1: memory read latency in cycles, 1..4.
REQ-005 wb_clk_i  in  1  clock; wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe and write enable.
REQ-007 wbs_sel_i  in  4  byte selects; wbs_adr_i  in  32  byte-agnostic word address; wbs_dat_i  in  32  write data.
REQ-008 wbs_ack_o  out  1  acknowledge; wbs_dat_o  out  32  read data.
REQ-009 wbs_mode, wbs_debug  out  1 each  control register bits.
REQ-010 mem_csb  out  NUM_CH  per-channel chip select, active-low; mem_web  out  NUM_CH  per-channel write enable, active-low.
REQ-011 mem_addr  out  ADDR_W  shared address; mem_wdata  out  DATA_W  shared write data; mem_rdata  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].

Function
REQ-012 Decode on adr[31:24]: 0x30 control; 0x31+c selects channel c for c<NUM_CH; everything else is unmapped.
REQ-013 Channel address fields: word index k = adr[WI_W-1:0]; entry = adr[WI_W+ADDR_W-1:WI_W]; k>=WORDS is unmapped.
REQ-014 Control map: 0x3000_0000 mode (bit0, R/W); 0x3000_0004 debug (bit0, R/W); 0x3000_0008 commit counter (32-bit, read-only, wraps 0xFFFF_FFFF->0).
REQ-015 States: IDLE, RD_ISSUE, RD_WAIT, RD_CAP, ACK. Requests are accepted only in IDLE, when cyc&stb are high; address, data, sel and we are registered on acceptance.
REQ-016 Write path: IDLE->ACK. wbs_ack_o is high for exactly one cycle, the cycle after acceptance.
REQ-017 Read path: IDLE->RD_ISSUE (csb low, web high, mem_addr driven)->RD_WAIT for MEM_LAT-1 cycles->RD_CAP (wbs_dat_o registered)->ACK. wbs_ack_o is high during ACK, MEM_LAT+2 cycles after acceptance, for one cycle.
REQ-018 Read data is word k of the selected channel entry; bits at or above DATA_W read as 0; control reads zero-extend the register bits.
REQ-019 Channel writes go to a WORDS x 32 staging buffer; only bytes with sel set update word k.
REQ-020 When k==WORDS-1, the ACK cycle commits the staging buffer to the selected channel (csb and web low, single cycle) using that access's entry address, and the commit counter increments.
REQ-021 Staging is shared across channels and is never cleared by commits. Words written to another channel before a commit are merged.
REQ-022 mem_csb and mem_web are all-ones in every cycle that has no read issue or commit; at most one channel is active per cycle.
REQ-023 Control writes obey sel[0] for bit0; a write to the counter is ignored.
REQ-024 Unmapped access: ack is given, writes have no effect, reads return 0.
REQ-025 wbs_dat_o holds its last value between reads.

Reset
REQ-026 On wb_rst_i, including mid-transaction: state=IDLE; wbs_ack_o=0; wbs_dat_o=0; wbs_mode=0; wbs_debug=0; counter=0; staging=0; mem_csb and mem_web all ones; mem_addr and mem_wdata 0. No pending commit survives reset.

Configuration
REQ-027 Macro WBS_MEM_ERR_EN defined: the port wbs_err_o (out, 1) exists. Unmapped accesses pulse wbs_err_o for one cycle in place of wbs_ack_o, at the same latency, with no side effects. Reads using the error path take the write-path latency.
REQ-028 Macro WBS_MEM_ERR_EN undefined: there is no wbs_err_o port, and REQ-024 applies.

Verification
REQ-029 DATA_W=64: write 0x3100_0040=0x1111_2222, then 0x3100_0041=0x0000_3333 -> one commit, ch0 entry 0x20=0x0000_3333_1111_2222, counter=1.
REQ-030 Read 0x3100_0041 after REQ-029 with MEM_LAT=2 -> ack 4 cycles after acceptance, dat=0x0000_3333, csb[0] low for exactly one cycle.
REQ-031 Write word0 with sel=4'b0011 data 0xAAAA_BBBB over staging 0xFFFF_FFFF -> staging word0=0xFFFF_BBBB.
REQ-032 Write to 0x3500_0000 with NUM_CH=4 -> ack, no csb activity; with WBS_MEM_ERR_EN defined -> err pulse, no ack.
REQ-033 Assert wb_rst_i during RD_WAIT -> no ack, all csb high, state IDLE, and the next read completes normally.
REQ-034 Write 1 to 0x3000_0000, then read it back -> wbs_mode=1, read data 0x0000_0001; write 5 to 0x3000_0008 -> counter unchanged.
